// File: rtl/uart_pkg.sv
// Shared UART constants plus the transmit-arbiter state encoding and defaults.
package uart_pkg;

  localparam int UART_DATA_LEN = 8;

  localparam int TX_ARB_N_REQ         = 4;
  localparam int TX_ARB_DATA_LEN      = UART_DATA_LEN;
  localparam int TX_ARB_START_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE
  } tx_arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = TX_ARB_N_REQ,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic             found;
  logic [PTR_W-1:0] pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        grant_idx  = pos;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters,
// with a start timeout while waiting for the transmitter to go busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ         = TX_ARB_N_REQ,
  parameter int DATA_LEN      = TX_ARB_DATA_LEN,
  parameter int START_TIMEOUT = TX_ARB_START_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_LEN-1:0] req_data,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          err,
  output logic [N_REQ-1:0]          grant,
  output logic [DATA_LEN-1:0]       tx_data,
  output logic                      tx_load,
  input  logic                      tx_empty,
  output logic                      busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

  tx_arb_state_e       state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    next_ptr;
  logic [CNT_W-1:0]    cnt;
  logic [N_REQ-1:0]    req_masked;
  logic [N_REQ-1:0]    sel_grant;
  logic [PTR_W-1:0]    sel_idx;
  logic [DATA_LEN-1:0] sel_data;

  // The requester just acked/errored still holds req this cycle; hide it so
  // IDLE does not grant it a second time before it can drop the request.
  assign req_masked = req & ~(ack | err);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req       (req_masked),
    .ptr       (rr_ptr),
    .grant     (sel_grant),
    .grant_idx (sel_idx)
  );

  assign sel_data = req_data[int'(sel_idx)*DATA_LEN +: DATA_LEN];
  assign next_ptr = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      grant   <= '0;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      ack     <= '0;
      err     <= '0;
      tx_load <= 1'b0;
      tx_data <= '0;
    end else begin
      ack     <= '0;
      err     <= '0;
      tx_load <= 1'b0;
      case (state)
        IDLE: begin
          if ((|req_masked) && tx_empty) begin
            grant   <= sel_grant;
            gnt_idx <= sel_idx;
            tx_data <= sel_data;
            state   <= LOAD;
          end
        end
        LOAD: begin
          tx_load <= 1'b1;
          cnt     <= '0;
          state   <= WAIT_START;
        end
        WAIT_START: begin
          if (!tx_empty) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
            err[gnt_idx] <= 1'b1;
            grant        <= '0;
            rr_ptr       <= next_ptr;
            state        <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_empty) begin
            ack[gnt_idx] <= 1'b1;
            grant        <= '0;
            rr_ptr       <= next_ptr;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple transmitter model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack, err, grant;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic        tx_empty;
  logic        busy;

  uart_tx_arbiter #(
    .N_REQ         (4),
    .DATA_LEN      (8),
    .START_TIMEOUT (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .err      (err),
    .grant    (grant),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_empty (tx_empty),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
    bit         is_err;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int grant_cyc = 0, load_cyc = 0, done_cyc = 0;
  int load_cnt = 0, done_cnt = 0;
  logic [7:0] load_data;
  logic [3:0] load_grant, prev_grant;
  bit auto_release = 1'b1;

  bit model_en = 1'b0;
  int model_delay = 2, model_len = 10;
  int start_cd = 0, run_cnt = 0;

  logic [7:0] d0 = 8'hA5, d1 = 8'h3C, d2 = 8'hC3, d3 = 8'h5A;

  always @(posedge clk) cyc++;

  // Transmitter model: goes busy model_delay cycles after tx_load for model_len cycles.
  always @(negedge clk) begin
    if (model_en) begin
      if (tx_load) start_cd = model_delay;
      else if (start_cd > 0) begin
        start_cd--;
        if (start_cd == 0) begin
          tx_empty = 1'b0;
          run_cnt  = model_len;
        end
      end else if (run_cnt > 0) begin
        run_cnt--;
        if (run_cnt == 0) tx_empty = 1'b1;
      end
    end
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   got_idx;
    if (rst) begin
      checks++;
      if (!$onehot0(grant) || !$onehot0(ack | err) || (tx_load && |(ack | err))) begin
        failures++;
        $display("FAIL invariant grant=%b ack=%b err=%b tx_load=%b", grant, ack, err, tx_load);
      end
      if (grant != 4'b0 && prev_grant == 4'b0) grant_cyc = cyc;
      if (tx_load) begin
        load_cnt++;
        load_data  = tx_data;
        load_grant = grant;
        load_cyc   = cyc;
        checks++;
        if (cyc - grant_cyc != 1) begin
          failures++;
          $display("FAIL grant_to_load latency got=%0d exp=1", cyc - grant_cyc);
        end
      end
      if (|(ack | err)) begin
        done_cnt++;
        done_cyc = cyc;
        got_idx = -1;
        for (int i = 0; i < 4; i++) if (ack[i] | err[i]) got_idx = i;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done got ack=%b err=%b exp none", ack, err);
        end else begin
          e = exp_q.pop_front();
          if (got_idx != e.idx || (|err) != e.is_err || load_data !== e.data ||
              load_grant !== (4'b1 << e.idx)) begin
            failures++;
            $display("FAIL scoreboard got idx=%0d err=%0b data=%h grant=%b exp idx=%0d err=%0b data=%h",
                     got_idx, |err, load_data, load_grant, e.idx, e.is_err, e.data);
          end
        end
      end
      if (auto_release) req = req & ~(ack | err);
    end
    prev_grant = grant;
  end

  task automatic push(input int idx, input logic [7:0] data, input bit is_err);
    exp_t e;
    e.idx = idx; e.data = data; e.is_err = is_err;
    exp_q.push_back(e);
  endtask

  task automatic reset_model();
    start_cd = 0;
    run_cnt  = 0;
    tx_empty = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s timeout done=%0d exp=%0d", name, done_cnt, target);
    end
  endtask

  task automatic wait_tx_running(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (busy && !tx_empty) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s never reached transmit got busy=%b tx_empty=%b", name, busy, tx_empty);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, ack, err, tx_load, tx_data, busy} !== 22'b0) begin
      failures++;
      $display("FAIL reset_outputs got grant=%b ack=%b err=%b load=%b data=%h busy=%b exp all 0",
               grant, ack, err, tx_load, tx_data, busy);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_single();
    int l0 = load_cnt, t = done_cnt;
    model_en = 1'b1;
    reset_model();
    push(0, d0, 1'b0);
    req = 4'b0001;
    wait_done(t + 1, 100, "single");
    checks++;
    if (grant !== 4'b0) begin
      failures++;
      $display("FAIL single_grant_clear got=%b exp=0000", grant);
    end
    @(negedge clk); #1;
    checks++;
    if (load_cnt - l0 != 1) begin
      failures++;
      $display("FAIL single_load_count got=%0d exp=1", load_cnt - l0);
    end
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_idle got grant=%b busy=%b data=%h exp 0000 0 a5", grant, busy, tx_data);
    end
  endtask

  task automatic test_round_robin();
    int t;
    apply_reset();
    t = done_cnt;
    auto_release = 1'b0;
    push(0, d0, 1'b0); push(1, d1, 1'b0); push(2, d2, 1'b0);
    push(3, d3, 1'b0); push(0, d0, 1'b0);
    req = 4'b1111;
    wait_done(t + 5, 400, "round_robin");
    req = 4'b0000;
    auto_release = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      failures++;
      $display("FAIL rr_settle got busy=%b grant=%b exp 0 0000", busy, grant);
    end
  endtask

  task automatic test_timeout();
    int t = done_cnt, l0 = load_cnt;
    apply_reset();
    model_en = 1'b0;
    tx_empty = 1'b1;
    push(1, d1, 1'b1);
    req = 4'b0010;
    wait_done(t + 1, 60, "timeout");
    checks++;
    if (done_cyc - load_cyc != 16) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=16", done_cyc - load_cyc);
    end
    checks++;
    if (load_cnt - l0 != 1) begin
      failures++;
      $display("FAIL timeout_load_count got=%0d exp=1", load_cnt - l0);
    end
    // Next grant order reveals the pointer left behind by the error.
    model_en = 1'b1;
    reset_model();
    push(2, d2, 1'b0); push(0, d0, 1'b0); push(1, d1, 1'b0);
    req = 4'b0111;
    wait_done(t + 4, 300, "after_timeout");
  endtask

  task automatic test_reset_mid();
    int t;
    apply_reset();
    model_len = 30;
    req = 4'b0100;
    wait_tx_running("reset_mid");
    rst = 1'b0;
    reset_model();
    #1;
    checks++;
    if ({grant, ack, err, tx_load, tx_data, busy} !== 22'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs got grant=%b ack=%b err=%b load=%b data=%h busy=%b exp all 0",
               grant, ack, err, tx_load, tx_data, busy);
    end
    repeat (2) @(negedge clk);
    model_len = 10;
    t = done_cnt;
    push(2, d2, 1'b0);
    #1 rst = 1'b1;
    wait_done(t + 1, 100, "reset_mid_resend");
  endtask

  task automatic test_empty_wait();
    int t = done_cnt;
    bit early = 1'b0;
    model_en = 1'b0;
    tx_empty = 1'b0;
    req = 4'b0001;
    repeat (6) begin
      @(negedge clk); #1;
      if (grant !== 4'b0 || busy) early = 1'b1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL empty_wait granted while tx busy got=1 exp=0");
    end
    push(0, d0, 1'b0);
    reset_model();
    model_en = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL empty_wait_grant got=%b exp=0001", grant);
    end
    wait_done(t + 1, 100, "empty_wait");
  endtask

  task automatic test_drop();
    int t = done_cnt;
    push(3, d3, 1'b0);
    req = 4'b1000;
    wait_tx_running("drop");
    push(0, d0, 1'b0);
    req = 4'b0001;
    wait_done(t + 1, 100, "drop_ack3");
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL drop_next_grant got=%b exp=0001", grant);
    end
    wait_done(t + 2, 100, "drop_ack0");
  endtask

  initial begin
    req      = 4'b0;
    req_data = {d3, d2, d1, d0};
    tx_empty = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_empty_wait();
    test_drop();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
